cnt_tracker: RTL and testbench

CNT_TRACKER -- requirements
Module: cnt_tracker

---
 rtl/cnt_tracker.sv | 165 ++++++++++++++++
 tb/tb_cnt_tracker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_tracker.sv
// cnt_tracker: monitors an upstream up/down counter sample stream.
// Flags samples that break the expected step or fall in forbidden ranges,
// counts erroneous samples (saturating), tracks signed min/max since reset,
// and optionally logs offending samples in a 4-entry FIFO.
// Optional feature macro: CNT_TRACKER_LOG_EN (defined = error log FIFO present;
// undefined = log outputs tied to 0 and log_ready ignored).
`timescale 1ns/1ps

module cnt_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [9:0] cnt,
    output logic       step_err,
    output logic       range_err,
    output logic [7:0] err_count,
    output logic [9:0] cnt_min,
    output logic [9:0] cnt_max,
    output logic       log_valid,
    input  logic       log_ready,
    output logic [9:0] log_data,
    output logic       log_overflow
);

    // Previous-sample state used for the step check.
    logic              r_prev_valid;
    logic signed [9:0] r_prev_cnt;
    logic              r_prev_mode;

    // Registered results.
    logic              r_step_err;
    logic              r_range_err;
    logic [7:0]        r_err_count;
    logic signed [9:0] r_cnt_min;
    logic signed [9:0] r_cnt_max;

    // Combinational evaluation of the current sample.
    logic signed [9:0]  w_cnt_s;
    logic signed [10:0] w_cnt_x;
    logic signed [10:0] w_prev_x;
    logic signed [10:0] w_expected;
    logic               w_check_en;
    logic               w_step_bad;
    logic               w_range_bad;
    logic               w_sample_err;

    // Evaluate the incoming sample against the step rule and the forbidden ranges.
    // Deltas use 11-bit signed arithmetic so e.g. -230 -> 235 never aliases to a match.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, so no latch is inferred.
        w_cnt_s    = cnt;
        w_cnt_x    = {cnt[9], cnt};
        w_prev_x   = {r_prev_cnt[9], r_prev_cnt};
        w_expected = '0;
        if (r_prev_mode) begin
            w_expected = w_prev_x + ((w_prev_x == -11'sd16) ? 11'sd10 : 11'sd5);
        end else begin
            w_expected = w_prev_x - ((w_prev_x == -11'sd2) ? 11'sd18 : 11'sd9);
        end
        // Limit regions near the counter ends are not step-checked.
        w_check_en   = r_prev_valid
                       && !( r_prev_mode && (w_prev_x > 11'sd225))
                       && !(!r_prev_mode && (w_prev_x < -11'sd221));
        w_step_bad   = w_check_en && (w_cnt_x != w_expected);
        w_range_bad  = (w_cnt_x < -11'sd230) || (w_cnt_x > 11'sd235) || (w_cnt_x == -11'sd11);
        w_sample_err = w_step_bad || w_range_bad;
    end

    // Sample cnt/mode, register error pulses, error count and min/max.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_prev_valid <= 1'b0;
            r_prev_cnt   <= '0;
            r_prev_mode  <= 1'b0;
            r_step_err   <= 1'b0;
            r_range_err  <= 1'b0;
            r_err_count  <= '0;
            r_cnt_min    <= '0;
            r_cnt_max    <= '0;
        end else begin
            r_prev_valid <= 1'b1;
            r_prev_cnt   <= w_cnt_s;
            r_prev_mode  <= mode;
            r_step_err   <= w_step_bad;
            r_range_err  <= w_range_bad;
            if (w_sample_err && (r_err_count != 8'd255)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (!r_prev_valid) begin
                r_cnt_min <= w_cnt_s;
                r_cnt_max <= w_cnt_s;
            end else begin
                if (w_cnt_s < r_cnt_min) r_cnt_min <= w_cnt_s;
                if (w_cnt_s > r_cnt_max) r_cnt_max <= w_cnt_s;
            end
        end
    end

    assign step_err  = r_step_err;
    assign range_err = r_range_err;
    assign err_count = r_err_count;
    assign cnt_min   = r_cnt_min;
    assign cnt_max   = r_cnt_max;

`ifdef CNT_TRACKER_LOG_EN
    localparam int LOG_DEPTH = 4;

    logic [9:0] r_log_mem [LOG_DEPTH];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_log_cnt;
    logic       r_log_ovf;

    logic       w_log_full;
    logic       w_log_pop;
    logic       w_log_push;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_log_full = (r_log_cnt == 3'(LOG_DEPTH));
    assign w_log_pop  = log_valid && log_ready;
    assign w_log_push = w_sample_err && (!w_log_full || w_log_pop);

    // Log storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; entries are only visible through the occupancy count.
        if (!rst && w_log_push) begin
            r_log_mem[r_wr_ptr] <= cnt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_log_cnt <= '0;
            r_log_ovf <= 1'b0;
        end else begin
            if (w_log_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_log_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_log_push, w_log_pop})
                2'b10:   r_log_cnt <= r_log_cnt + 3'd1;
                2'b01:   r_log_cnt <= r_log_cnt - 3'd1;
                default: r_log_cnt <= r_log_cnt;
            endcase
            if (w_sample_err && !w_log_push) begin
                r_log_ovf <= 1'b1;
            end
        end
    end

    assign log_valid    = (r_log_cnt != 3'd0);
    assign log_data     = log_valid ? r_log_mem[r_rd_ptr] : 10'd0;
    assign log_overflow = r_log_ovf;
`else
    logic w_unused_log_ready;

    assign w_unused_log_ready = log_ready;
    assign log_valid          = 1'b0;
    assign log_data           = 10'd0;
    assign log_overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_tracker.sv
// Self-checking bench for cnt_tracker: directed vector table, hand-written
// multi-cycle sequences (FIFO overflow/drain, reset mid-stream, saturation)
// and randomized stimulus against an integer-level reference model.
// Log expectations follow CNT_TRACKER_LOG_EN as seen by this compile.
`timescale 1ns/1ps

module tb_cnt_tracker;

`ifdef CNT_TRACKER_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [9:0] cnt;
    logic       step_err;
    logic       range_err;
    logic [7:0] err_count;
    logic [9:0] cnt_min;
    logic [9:0] cnt_max;
    logic       log_valid;
    logic       log_ready;
    logic [9:0] log_data;
    logic       log_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    cnt_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .cnt          (cnt),
        .step_err     (step_err),
        .range_err    (range_err),
        .err_count    (err_count),
        .cnt_min      (cnt_min),
        .cnt_max      (cnt_max),
        .log_valid    (log_valid),
        .log_ready    (log_ready),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model (plain integer arithmetic) ----------------
    bit md_pv, md_pm, md_step, md_range, md_ovf;
    int md_ps, md_errc, md_min, md_max;
    int md_q[$];

    function automatic int next_expected();
        if (md_pm) return md_ps + ((md_ps == -16) ? 10 : 5);
        return md_ps - ((md_ps == -2) ? 18 : 9);
    endfunction

    task automatic model_step(input bit r, input bit m, input int c, input bit rdy);
        bit chk;
        bit err;
        if (r) begin
            md_pv = 0; md_pm = 0; md_ps = 0;
            md_step = 0; md_range = 0; md_ovf = 0;
            md_errc = 0; md_min = 0; md_max = 0;
            md_q.delete();
        end else begin
            chk      = md_pv && !(md_pm && md_ps > 225) && !(!md_pm && md_ps < -221);
            md_step  = chk && (c != next_expected());
            md_range = (c < -230) || (c > 235) || (c == -11);
            err      = md_step || md_range;
            if (err && md_errc < 255) md_errc++;
            if (!md_pv) begin
                md_min = c;
                md_max = c;
            end else begin
                if (c < md_min) md_min = c;
                if (c > md_max) md_max = c;
            end
            if (LOG_EN) begin
                if (md_q.size() > 0 && rdy) void'(md_q.pop_front());
                if (err) begin
                    if (md_q.size() < 4) md_q.push_back(c);
                    else md_ovf = 1;
                end
            end
            md_pv = 1; md_ps = c; md_pm = m;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic signed [31:0] act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_step"},  step_err,  32'(md_step));
        check({tag, "_range"}, range_err, 32'(md_range));
        check({tag, "_errc"},  err_count, md_errc);
        check({tag, "_min"},   $signed(cnt_min), md_min);
        check({tag, "_max"},   $signed(cnt_max), md_max);
        check({tag, "_lv"},    log_valid, (md_q.size() > 0) ? 1 : 0);
        check({tag, "_ld"},    $signed(log_data), (md_q.size() > 0) ? md_q[0] : 0);
        check({tag, "_ovf"},   log_overflow, 32'(md_ovf));
    endtask

    // Apply one sample, advance one clock, update model, compare #1 after the edge.
    task automatic drive(input bit r, input bit m, input int c, input bit rdy, input string tag);
        logic [9:0] cv;
        int         cw;
        cv = c[9:0];
        cw = int'($signed(cv));
        rst = r; mode = m; cnt = cv; log_ready = rdy;
        @(posedge clk);
        model_step(r, m, cw, rdy);
        #1;
        check_model(tag);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit r;  bit m;  int c;
        bit s;  bit rg; int ec; int mn; int mx; bit lv; int ld;
    } vec_t;

    vec_t tbl[28];

    initial begin
        int heads[4];
        int hv;
        int sel;
        int c;
        int specials[9];

        rst = 1'b1; mode = 1'b1; cnt = '0; log_ready = 1'b0;
        model_step(1, 1, 0, 0);

        //          r  m   c     s rg ec  mn    mx   lv  ld
        tbl[0]  = '{1, 1,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[1]  = '{0, 1,  -50,  0, 0, 0,  -50,  -50, 0,    0};
        tbl[2]  = '{0, 1,  -45,  0, 0, 0,  -50,  -45, 0,    0};
        tbl[3]  = '{0, 1,  -40,  0, 0, 0,  -50,  -40, 0,    0};
        tbl[4]  = '{1, 1,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[5]  = '{0, 1,  -16,  0, 0, 0,  -16,  -16, 0,    0};
        tbl[6]  = '{0, 1,   -6,  0, 0, 0,  -16,   -6, 0,    0};
        tbl[7]  = '{1, 1,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[8]  = '{0, 1,  -16,  0, 0, 0,  -16,  -16, 0,    0};
        tbl[9]  = '{0, 1,  -11,  1, 1, 1,  -16,  -11, 1,  -11};
        tbl[10] = '{1, 0,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[11] = '{0, 0,   -2,  0, 0, 0,   -2,   -2, 0,    0};
        tbl[12] = '{0, 0,  -20,  0, 0, 0,  -20,   -2, 0,    0};
        tbl[13] = '{1, 0,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[14] = '{0, 0,   -2,  0, 0, 0,   -2,   -2, 0,    0};
        tbl[15] = '{0, 0,  -11,  1, 1, 1,  -11,   -2, 1,  -11};
        tbl[16] = '{1, 1,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[17] = '{0, 1,  225,  0, 0, 0,  225,  225, 0,    0};
        tbl[18] = '{0, 1,  230,  0, 0, 0,  225,  230, 0,    0};
        tbl[19] = '{0, 1,  236,  0, 1, 1,  225,  236, 1,  236};
        tbl[20] = '{1, 0,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[21] = '{0, 0, -221,  0, 0, 0, -221, -221, 0,    0};
        tbl[22] = '{0, 0, -230,  0, 0, 0, -230, -221, 0,    0};
        tbl[23] = '{0, 0, -231,  0, 1, 1, -231, -221, 1, -231};
        tbl[24] = '{1, 1,    0,  0, 0, 0,    0,    0, 0,    0};
        tbl[25] = '{0, 1, -230,  0, 0, 0, -230, -230, 0,    0};
        tbl[26] = '{0, 1,  235,  1, 0, 1, -230,  235, 1,  235};
        tbl[27] = '{0, 1, -231,  0, 1, 2, -231,  235, 1,  235};

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].r, tbl[i].m, tbl[i].c, 1'b0, $sformatf("m%0d", i));
            check($sformatf("v%0d_step", i),  step_err,  32'(tbl[i].s));
            check($sformatf("v%0d_range", i), range_err, 32'(tbl[i].rg));
            check($sformatf("v%0d_errc", i),  err_count, tbl[i].ec);
            check($sformatf("v%0d_min", i),   $signed(cnt_min), tbl[i].mn);
            check($sformatf("v%0d_max", i),   $signed(cnt_max), tbl[i].mx);
            check($sformatf("v%0d_lv", i),    log_valid, LOG_EN ? 32'(tbl[i].lv) : 0);
            check($sformatf("v%0d_ld", i),    $signed(log_data), LOG_EN ? tbl[i].ld : 0);
        end

        // ---- overflow: 5 errors with consumer stalled, then drain in order ----
        heads = '{240, 250, 260, 270};
        drive(1, 1, 0, 0, "ov_rst");
        for (int i = 0; i < 5; i++) drive(0, 1, 240 + 10 * i, 0, "ov_fill");
        check("ov_errc", err_count, 5);
        check("ov_flag", log_overflow, LOG_EN ? 1 : 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ov_head%0d", i), $signed(log_data), LOG_EN ? heads[i] : 0);
            check($sformatf("ov_lv%0d", i), log_valid, LOG_EN ? 1 : 0);
            drive(0, 1, 100 + 5 * i, 1, "ov_pop");
        end
        check("ov_empty", log_valid, 0);
        check("ov_sticky", log_overflow, LOG_EN ? 1 : 0);

        // ---- reset mid-stream with errors logged ----
        drive(0, 1, 300, 1, "rm_err");
        drive(0, 1, 100, 0, "rm_pre");
        drive(1, 1, 0, 0, "rm_rst");
        check("rm_errc", err_count, 0);
        check("rm_lv", log_valid, 0);
        check("rm_ovf", log_overflow, 0);
        drive(0, 1, -50, 0, "rm_post");
        check("rm_nostep", step_err, 0);
        check("rm_min", $signed(cnt_min), -50);

        // ---- full FIFO with simultaneous push and pop ----
        drive(1, 1, 0, 0, "fp_rst");
        for (int i = 0; i < 4; i++) drive(0, 1, 240 + 10 * i, 0, "fp_fill");
        drive(0, 1, 280, 1, "fp_pushpop");
        check("fp_ovf", log_overflow, 0);
        check("fp_head", $signed(log_data), LOG_EN ? 250 : 0);

        // ---- err_count saturation ----
        drive(1, 1, 0, 0, "sat_rst");
        for (int i = 0; i < 260; i++) drive(0, 1, 300, 1, "sat");
        check("sat_errc", err_count, 255);

        // ---- randomized stimulus against the model ----
        specials = '{-16, -2, -11, -230, -231, 235, 236, 225, -221};
        drive(1, 1, 0, 0, "rnd_rst");
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5 && md_pv) begin
                c = next_expected();
            end else if (sel < 7) begin
                hv = $urandom_range(0, 8);
                c  = specials[hv];
            end else begin
                c = int'($urandom_range(0, 1023)) - 512;
            end
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), c,
                  ($urandom_range(0, 2) == 0), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
